interrupt_controller: RTL
=========================

// Module: interrupt_controller
// PURPOSE
//  Collects external event lines (push-buttons, I/O-mapped peripherals) and arbitrates them into one
//  interrupt request towards the single-cycle CPU. Feeds the 8-bit interruptions path of the I/O
//  manager. Detects rising edges, holds pending/mask state, picks one source by fixed priority and
//  sequences a req/ack/done handshake so only one interrupt is in service at a time.
// PARAMETERS
//  N_SRC   8   number of interrupt sources, max 8; vector width is fixed at 3
//  MASK_RV 8'hFF  reset value of mask register (1 = source enabled)
// PORTS
//  clk         in   1      system clock; all state updates on rising edge
//  reset       in   1      synchronous, active-high; clears all state
//  irq_in      in   N_SRC  asynchronous event lines, level; rising edge = event
//  mask_we     in   1      load mask register from mask_in this cycle
//  mask_in     in   N_SRC  new mask value
//  int_ack     in   1      CPU accepts the current request (vector sampled)
//  int_done    in   1      CPU end-of-interrupt for the in-service source
//  int_req     out  1      interrupt request to CPU, registered
//  int_vector  out  3      index of requested/in-service source, registered
//  pending     out  N_SRC  pending flags (readable via I/O map)
//  mask        out  N_SRC  current mask register
//  in_service  out  1      high while an interrupt is acknowledged and not yet done
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//   - int_req=0, int_vector=0, pending=0, in_service=0, mask=MASK_RV, FSM=IDLE.
//   - Synchronizer and prev-sample flops clear to 0.
//   - A line held high across reset release yields exactly one event.
//   - Reset mid-handshake aborts it; no ack/done is owed.
//  Input path: 2-flop synchronizer -> prev flop; edge = sync2 & ~prev.
//   - Edge sets pending[i] at the following clk edge.
//   - irq_in rising before edge k -> pending at edge k+2 -> int_req high after edge k+3 (IDLE case).
//  Pending: set by edge, cleared only by int_ack for bit int_vector.
//   - Set and clear of the same bit in the same cycle -> set wins (bit stays 1).
//   - Repeated edges while pending collapse into one event.
//  Mask: mask_we loads mask_in next edge. Masked sources still latch pending but are not selected.
//  Selection: eligible = pending & mask; lowest index wins (bit 0 highest priority).
//  FSM (registered, 2-bit):
//   - IDLE: if |eligible -> latch int_vector=winner, int_req=1, go REQ; else stay.
//   - REQ: int_req held, int_vector frozen (mask changes/new edges do not alter it).
//     On int_ack: clear pending[int_vector], int_req=0, in_service=1, go SERVICE.
//   - SERVICE: on int_done -> in_service=0, go IDLE. No nesting; new edges only set pending.
//  The first eligible check after int_done happens in IDLE, so back-to-back interrupts have
//  >=1 idle cycle with int_req=0.
//  Ignored inputs: int_ack outside REQ; int_done outside SERVICE.
//  Same-cycle ack+done in REQ: treat as ack only.
//  Unused bits: if N_SRC<8, bits above N_SRC-1 are not present; int_vector < N_SRC always.
// STRUCTURE
//  Shared include intc_defs.vh: FSM state codes (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), VEC_W=3.
//  Sub-module edge_sync #(N_SRC): per-bit synchronizer + prev flop, outputs one-cycle edge pulses.
//  Priority encoder and FSM stay in this module.
//  Mask and pending registers are plain flops; reuse register #(N) is allowed for mask.
// TESTING
//  1 Reset, irq_in[2] 0->1 -> pending=8'h04 at edge +3, int_req=1 and int_vector=2 at edge +4.
//  2 irq_in[5] and irq_in[1] rise same cycle -> vector 1 first. After ack+done and one idle
//    cycle -> vector 5; pending ends 8'h00.
//  3 mask_in=8'hFE (mask_we), edge on bit0 -> pending=8'h01, int_req stays 0.
//    Then mask_in=8'hFF -> int_req=1, vector 0.
//  4 In REQ with vector 3, a new edge on bit0 arrives -> int_vector stays 3.
//    After ack, pending=8'h01, in_service=1, int_req=0.
//  5 Edge on bit4 in the same cycle as int_ack for vector 4 -> pending[4]=1 afterwards;
//    re-requested after done.
//  6 reset asserted in SERVICE with pending=8'h0A -> next edge: all outputs at reset values,
//    mask=8'hFF. Spurious int_done/int_ack in IDLE -> no change.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared types, widths and priority helper for the interrupt controller
package interrupt_controller_pkg;

  localparam int VEC_W   = 3;
  localparam int MAX_SRC = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

  // Bit 0 has the highest priority, so the scan runs downward and the last hit wins.
  function automatic logic [VEC_W-1:0] lowest_set(input logic [MAX_SRC-1:0] v);
    lowest_set = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = VEC_W'(i);
    end
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - event, mask and CPU handshake bundle of the interrupt controller
interface interrupt_controller_if
  import interrupt_controller_pkg::*;
#(
  parameter int N_SRC = 8
);

  logic [N_SRC-1:0] irq_in;
  logic             mask_we;
  logic [N_SRC-1:0] mask_in;
  logic             int_ack;
  logic             int_done;
  logic             int_req;
  logic [VEC_W-1:0] int_vector;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic             in_service;

  modport master (
    output irq_in, mask_we, mask_in, int_ack, int_done,
    input  int_req, int_vector, pending, mask, in_service
  );

  modport slave (
    input  irq_in, mask_we, mask_in, int_ack, int_done,
    output int_req, int_vector, pending, mask, in_service
  );

endinterface

// File: rtl/interrupt_controller_edge_sync.sv
// rtl/interrupt_controller_edge_sync.sv - two-flop synchronizer plus previous-sample flop per line, one-cycle rising-edge pulses
module interrupt_controller_edge_sync #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] irq_i,
  output logic [N-1:0] edge_o
);

  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;
  logic [N-1:0] prev_q;

  // Clearing prev on reset turns a line held high across reset into exactly one event.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - pending/mask state, fixed-priority selection and req/ack/done sequencing towards the CPU
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int             N_SRC   = 8,
  parameter logic [N_SRC-1:0] MASK_RV = '1
) (
  input logic                  clk,
  input logic                  reset,
  interrupt_controller_if.slave bus
);

  intc_state_e      state_q, state_d;
  logic             int_req_q, int_req_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             in_service_q, in_service_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edge_pulse;
  logic [N_SRC-1:0] pend_clr;
  logic [MAX_SRC-1:0] eligible;

  interrupt_controller_edge_sync #(.N(N_SRC)) u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .irq_i  (bus.irq_in),
    .edge_o (edge_pulse)
  );

  // Sources above N_SRC-1 pad to zero, so the winner is always a real source.
  assign eligible = MAX_SRC'(pending_q & mask_q);

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    vec_d        = vec_q;
    in_service_d = in_service_q;
    pend_clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          vec_d     = lowest_set(eligible);
          int_req_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.int_ack) begin
          pend_clr     = N_SRC'(1) << vec_q;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          state_d      = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (bus.int_done) begin
          in_service_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // OR-ing the edge after the clear lets a coincident new event survive the ack.
    pending_d = (pending_q & ~pend_clr) | edge_pulse;
    mask_d    = bus.mask_we ? bus.mask_in : mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      int_req_q    <= 1'b0;
      vec_q        <= '0;
      in_service_q <= 1'b0;
      pending_q    <= '0;
      mask_q       <= MASK_RV;
    end else begin
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      vec_q        <= vec_d;
      in_service_q <= in_service_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
    end
  end

  assign bus.int_req    = int_req_q;
  assign bus.int_vector = vec_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;
  assign bus.in_service = in_service_q;

endmodule
